// File: rtl/audio_clip_bram_player.sv
// audio_clip_bram_player
//   Streams unsigned PCM samples from a shared audio BRAM at a fixed sample
//   rate. Any clip (base address + length) can be played on request, either
//   one-shot or looping, with stop, retrigger and completion signalling.
//
// Ports
//   CLK              in   system clock, rising edge
//   RESET_N          in   asynchronous active-low reset
//   start            in   one-cycle clip request (samples clip_base/clip_len/loop_en)
//   clip_base        in   first sample address of the clip
//   clip_len         in   clip length in samples (0 = request ignored)
//   loop_en          in   1 = loop until stopped, 0 = one-shot
//   stop             in   one-cycle abort request
//   bram_addr        out  registered BRAM read address
//   bram_data_out    in   BRAM read data (BRAM_LATENCY cycles after address)
//   audio_sample_out out  registered output sample
//   sample_tick      out  one-cycle pulse on each audio_sample_out update
//   busy             out  high while a clip is playing
//   done             out  one-cycle pulse when a one-shot clip finishes
module audio_clip_bram_player #(
    parameter int unsigned CLK_FREQ_HZ    = 100_000_000,
    parameter int unsigned SAMPLE_RATE_HZ = 16_000,
    parameter int unsigned ADDRESS_WIDTH  = 16,
    parameter int unsigned SAMPLE_WIDTH   = 8,
    parameter int unsigned BRAM_LATENCY   = 1
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] clip_base,
    input  logic [ADDRESS_WIDTH-1:0] clip_len,
    input  logic                     loop_en,
    input  logic                     stop,
    output logic [ADDRESS_WIDTH-1:0] bram_addr,
    input  logic [SAMPLE_WIDTH-1:0]  bram_data_out,
    output logic [SAMPLE_WIDTH-1:0]  audio_sample_out,
    output logic                     sample_tick,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned TICK_LIMIT = CLK_FREQ_HZ / SAMPLE_RATE_HZ - 1;
    localparam int unsigned DIV_W      = (TICK_LIMIT > 0) ? $clog2(TICK_LIMIT + 1) : 1;
    localparam logic [SAMPLE_WIDTH-1:0] MID = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    localparam logic [1:0] SETTLE_INIT = 2'(BRAM_LATENCY);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t                   r_state, w_next_state;
    logic [DIV_W-1:0]         r_div;
    logic [ADDRESS_WIDTH-1:0] r_base, w_base;
    logic [ADDRESS_WIDTH-1:0] r_len, w_len;
    logic                     r_loop, w_loop;
    logic [ADDRESS_WIDTH-1:0] r_ptr, w_ptr;
    logic [ADDRESS_WIDTH-1:0] r_remaining, w_remaining;
    logic [1:0]               r_settle, w_settle;
    logic [SAMPLE_WIDTH-1:0]  r_sample, w_sample;
    logic                     r_sample_tick;
    logic                     r_busy;
    logic                     r_done, w_done;
    logic                     w_tick;
    logic                     w_accept;

    assign w_tick   = (r_div == DIV_W'(TICK_LIMIT));
    assign w_accept = start && !stop && (clip_len != '0);

    always_comb begin
        w_next_state = r_state;
        w_base       = r_base;
        w_len        = r_len;
        w_loop       = r_loop;
        w_ptr        = r_ptr;
        w_remaining  = r_remaining;
        w_settle     = (r_settle != '0) ? r_settle - 2'd1 : r_settle;
        w_sample     = r_sample;
        w_done       = 1'b0;

        if (r_state == PLAY && stop) begin
            w_next_state = IDLE;
            if (w_tick) w_sample = MID;
        end else if (w_accept) begin
            // Accepted request (fresh or retrigger); a coincident tick emits silence.
            w_next_state = PLAY;
            w_base       = clip_base;
            w_len        = clip_len;
            w_loop       = loop_en;
            w_ptr        = clip_base;
            w_remaining  = clip_len;
            w_settle     = SETTLE_INIT;
            if (w_tick) w_sample = MID;
        end else if (w_tick) begin
            if (r_state == IDLE || r_settle != '0) begin
                w_sample = MID;
            end else begin
                w_sample    = bram_data_out;
                w_ptr       = r_ptr + ADDRESS_WIDTH'(1);
                w_settle    = SETTLE_INIT;
                w_remaining = r_remaining - ADDRESS_WIDTH'(1);
                if (r_remaining == ADDRESS_WIDTH'(1)) begin
                    if (r_loop) begin
                        w_ptr       = r_base;
                        w_remaining = r_len;
                    end else begin
                        w_next_state = IDLE;
                        w_done       = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state       <= IDLE;
            r_div         <= '0;
            r_base        <= '0;
            r_len         <= '0;
            r_loop        <= 1'b0;
            r_ptr         <= '0;
            r_remaining   <= '0;
            r_settle      <= '0;
            r_sample      <= MID;
            r_sample_tick <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_div         <= w_tick ? '0 : r_div + DIV_W'(1);
            r_base        <= w_base;
            r_len         <= w_len;
            r_loop        <= w_loop;
            r_ptr         <= w_ptr;
            r_remaining   <= w_remaining;
            r_settle      <= w_settle;
            r_sample      <= w_sample;
            r_sample_tick <= w_tick;
            r_busy        <= (w_next_state == PLAY);
            r_done        <= w_done;
        end
    end

    assign bram_addr        = r_ptr;
    assign audio_sample_out = r_sample;
    assign sample_tick      = r_sample_tick;
    assign busy             = r_busy;
    assign done             = r_done;

endmodule

// File: tb/tb_audio_clip_bram_player.sv
// tb_audio_clip_bram_player
//   Self-checking bench: ticks every 10 cycles, BRAM modelled as
//   mem[a] = a[7:0] with one cycle of read latency. Expected values come
//   from a clip-level model (sample k of a clip is mem[base + k mod len]).
module tb_audio_clip_bram_player;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        start = 1'b0;
    logic [15:0] clip_base = '0;
    logic [15:0] clip_len = '0;
    logic        loop_en = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] bram_addr;
    logic [7:0]  bram_q;
    logic [7:0]  audio_sample_out;
    logic        sample_tick;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    audio_clip_bram_player #(
        .CLK_FREQ_HZ(160),
        .SAMPLE_RATE_HZ(16),
        .ADDRESS_WIDTH(16),
        .SAMPLE_WIDTH(8),
        .BRAM_LATENCY(1)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .start(start),
        .clip_base(clip_base),
        .clip_len(clip_len),
        .loop_en(loop_en),
        .stop(stop),
        .bram_addr(bram_addr),
        .bram_data_out(bram_q),
        .audio_sample_out(audio_sample_out),
        .sample_tick(sample_tick),
        .busy(busy),
        .done(done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) bram_q <= bram_addr[7:0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge at which sample_tick is high (bounded).
    task automatic wait_sample(output int cycles);
        cycles = 0;
        do begin
            @(negedge CLK);
            cycles++;
        end while (!sample_tick && cycles < 40);
        check("tick_seen", sample_tick, 1);
    endtask

    // Drive a one-cycle request from the current negedge.
    task automatic req(input logic [15:0] b, input logic [15:0] l, input logic lp, input logic stp, input logic strt);
        start = strt; stop = stp;
        clip_base = b; clip_len = l; loop_en = lp;
        @(negedge CLK);
        start = 1'b0; stop = 1'b0;
    endtask

    function automatic logic [7:0] m_sample(logic [15:0] b, logic [15:0] l, logic lp, int k);
        logic [15:0] a;
        if (!lp && k >= int'(l)) return 8'h80;
        a = b + 16'(k % int'(l));
        return a[7:0];
    endfunction

    function automatic logic [15:0] m_addr(logic [15:0] b, logic [15:0] l, logic lp, int k);
        if (lp) return b + 16'((k + 1) % int'(l));
        return b + 16'(((k + 1) < int'(l)) ? (k + 1) : int'(l));
    endfunction

    // Check n sample ticks of a clip that has already been accepted.
    task automatic play(input string tag, input logic [15:0] b, input logic [15:0] l, input logic lp, input int n);
        int c;
        for (int k = 0; k < n; k++) begin
            wait_sample(c);
            check({tag, "_sample"}, audio_sample_out, m_sample(b, l, lp, k));
            check({tag, "_done"},   done, (!lp && k == int'(l) - 1));
            check({tag, "_busy"},   busy, (lp || k < int'(l) - 1));
            check({tag, "_addr"},   bram_addr, m_addr(b, l, lp, k));
        end
    endtask

    task automatic start_clip(input string tag, input logic [15:0] b, input logic [15:0] l, input logic lp);
        req(b, l, lp, 1'b0, 1'b1);
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_addr0"}, bram_addr, b);
    endtask

    task automatic stop_and_check(input string tag);
        int c;
        req('0, '0, 1'b0, 1'b1, 1'b0);
        check({tag, "_stop_busy"}, busy, 0);
        wait_sample(c);
        check({tag, "_stop_sample"}, audio_sample_out, 8'h80);
        check({tag, "_stop_done"}, done, 0);
        check({tag, "_stop_busy2"}, busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        logic [15:0] rb, rl;
        logic rlp;

        // Reset values while held.
        repeat (3) @(negedge CLK);
        check("rst_addr", bram_addr, 16'h0000);
        check("rst_sample", audio_sample_out, 8'h80);
        check("rst_tick", sample_tick, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        RESET_N = 1'b1;

        // Idle: tick period and silence.
        wait_sample(c);
        for (int i = 0; i < 3; i++) begin
            wait_sample(c);
            check("idle_period", c, 10);
            check("idle_sample", audio_sample_out, 8'h80);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
        end

        // One-shot 0x10 x3, then one idle tick.
        start_clip("oneshot", 16'h0010, 16'd3, 1'b0);
        play("oneshot", 16'h0010, 16'd3, 1'b0, 4);

        // Loop 0x20 x2 for five ticks, then stop.
        start_clip("loop", 16'h0020, 16'd2, 1'b1);
        play("loop", 16'h0020, 16'd2, 1'b1, 5);
        stop_and_check("loop");

        // Address wrap past the top of memory.
        start_clip("wrap", 16'hFFFE, 16'd4, 1'b0);
        play("wrap", 16'hFFFE, 16'd4, 1'b0, 5);

        // Retrigger a looping clip with a one-shot; no done for the old clip.
        start_clip("retrig_a", 16'h0020, 16'd2, 1'b1);
        play("retrig_a", 16'h0020, 16'd2, 1'b1, 2);
        start_clip("retrig_b", 16'h0030, 16'd1, 1'b0);
        play("retrig_b", 16'h0030, 16'd1, 1'b0, 2);

        // Start in the tick cycle: that tick is silent, clip begins on the next.
        repeat (9) @(negedge CLK);
        start = 1'b1; clip_base = 16'h0040; clip_len = 16'd2; loop_en = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        check("coinc_tick", sample_tick, 1);
        check("coinc_sample", audio_sample_out, 8'h80);
        check("coinc_busy", busy, 1);
        play("coinc", 16'h0040, 16'd2, 1'b0, 3);

        // start together with stop is ignored.
        req(16'h0050, 16'd5, 1'b0, 1'b1, 1'b1);
        check("startstop_busy", busy, 0);
        wait_sample(c);
        check("startstop_sample", audio_sample_out, 8'h80);
        check("startstop_busy2", busy, 0);

        // Zero-length request is ignored.
        req(16'h0060, 16'd0, 1'b0, 1'b0, 1'b1);
        check("len0_busy", busy, 0);
        wait_sample(c);
        check("len0_sample", audio_sample_out, 8'h80);
        check("len0_busy2", busy, 0);

        // Randomized clips.
        for (int it = 0; it < 8; it++) begin
            rb  = 16'($urandom);
            rl  = 16'($urandom_range(1, 5));
            rlp = 1'($urandom_range(0, 1));
            start_clip("rand", rb, rl, rlp);
            if (rlp) begin
                play("rand", rb, rl, rlp, 2 * int'(rl) + 1);
                stop_and_check("rand");
            end else begin
                play("rand", rb, rl, rlp, int'(rl) + 1);
            end
        end

        // Reset mid-clip, asserted while sample_tick is high.
        start_clip("rstmid", 16'h0070, 16'd5, 1'b1);
        play("rstmid", 16'h0070, 16'd5, 1'b1, 2);
        RESET_N = 1'b0;
        #1;
        check("rstmid_tick", sample_tick, 0);
        check("rstmid_sample", audio_sample_out, 8'h80);
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        check("rstmid_addr", bram_addr, 16'h0000);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        // Counting the release cycle as cycle 1, the first pulse lands in cycle 11.
        c = 0;
        do begin
            @(negedge CLK);
            c++;
        end while (!sample_tick && c < 40);
        check("rel_first_tick", c, 10);
        check("rel_sample", audio_sample_out, 8'h80);
        check("rel_busy", busy, 0);
        check("rel_done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/audio_clip_bram_player.md
# audio_clip_bram_player

Multi-clip, parametrised successor to the single-clip sample player. Streams unsigned PCM samples from a shared audio BRAM at a fixed sample rate, playing any clip (base address + length) on request in one-shot or loop mode, with stop, retrigger and completion signalling. Sits between the game-event logic, which issues clip requests, and the PWM/DAC audio output stage, which consumes `audio_sample_out` on `sample_tick`.

## Interface
- `CLK_FREQ_HZ`, 100_000_000: system clock frequency.
- `SAMPLE_RATE_HZ`, 16_000: output sample rate; `TICK_LIMIT = CLK_FREQ_HZ/SAMPLE_RATE_HZ - 1`.
- `ADDRESS_WIDTH`, 16: BRAM address width; also clip length width.
- `SAMPLE_WIDTH`, 8: sample width; silence value `MID = 2**(SAMPLE_WIDTH-1)` (0x80 at 8 bits).
- `BRAM_LATENCY`, 1: BRAM read latency in cycles, legal 1..3.

- `CLK  in  1`: single clock; all logic on rising edge.
- `RESET_N  in  1`: asynchronous, active-low reset.
- `start  in  1`: one-cycle clip request; samples `clip_base`, `clip_len`, `loop_en` in the same cycle.
- `clip_base  in  ADDRESS_WIDTH`: first sample address of the clip.
- `clip_len  in  ADDRESS_WIDTH`: clip length in samples; 0 means the request is ignored.
- `loop_en  in  1`: 1 = loop the clip until stopped, 0 = one-shot.
- `stop  in  1`: one-cycle abort request.
- `bram_addr  out  ADDRESS_WIDTH`: registered read address to BRAM.
- `bram_data_out  in  SAMPLE_WIDTH`: BRAM read data, valid `BRAM_LATENCY` cycles after `bram_addr` changes.
- `audio_sample_out  out  SAMPLE_WIDTH`: registered output sample.
- `sample_tick  out  1`: one-cycle pulse marking each `audio_sample_out` update.
- `busy  out  1`: high while in PLAY.
- `done  out  1`: one-cycle pulse when a one-shot clip finishes naturally.

## Operation
- Divider counts 0..TICK_LIMIT continuously, including while idle. Internal `tick` is high when divider == TICK_LIMIT.
- State machine has two states, IDLE and PLAY. Latched registers: `base`, `len`, `loop`, pointer `ptr` (driven onto `bram_addr`), `remaining`, settle counter `settle`.
- IDLE + `start` with `clip_len != 0`:
  - latch inputs;
  - `ptr <= clip_base`, `remaining <= clip_len`, `settle <= BRAM_LATENCY`;
  - go to PLAY.
- PLAY + `start` with `clip_len != 0` is a retrigger. It follows the same actions and discards the old clip. There is no `done` for the discarded clip.
- Priority within one cycle: `stop` > `start` > `tick`.
  - `stop` in PLAY: go to IDLE next cycle, no `done`. `stop` in IDLE: no effect.
  - `start` together with `stop` is ignored.
- `settle` decrements each cycle while nonzero. A tick that arrives while `settle != 0`, or in the same cycle as an accepted `start`, emits MID and does not advance `ptr` or `remaining`.
- PLAY `tick` with `settle == 0`:
  - `audio_sample_out <= bram_data_out`;
  - `ptr <= ptr + 1`, modulo 2^ADDRESS_WIDTH (clips may wrap past the top address);
  - `settle <= BRAM_LATENCY`;
  - `remaining <= remaining - 1`.
- Last sample (`remaining == 1`) on that tick:
  - loop: `ptr <= base`, `remaining <= len`;
  - one-shot: go to IDLE and pulse `done`.
- IDLE `tick`: `audio_sample_out <= MID`.
- `busy` = (state == PLAY), registered.

## Timing
- Reset values:
  - `bram_addr` = 0, `audio_sample_out` = MID;
  - `sample_tick`, `busy`, `done` = 0;
  - divider = 0, state = IDLE.
- Reset may be asserted at any point mid-clip. All state returns to the reset values immediately, with no `done`.
- `sample_tick` is high in cycle T+1 for a tick in cycle T. It coincides with the new value on `audio_sample_out`. Period is exactly TICK_LIMIT+1 cycles, always.
- `busy` rises the cycle after an accepted `start`. It falls in the cycle after the final tick or `stop`.
- `done` is high in the same cycle as the `sample_tick` that carries the clip's last sample.
- `bram_addr` changes only in the cycle after `start` or a playing tick. BRAM data is sampled no earlier than `BRAM_LATENCY` cycles after any address change.

## Test plan
Bench uses CLK_FREQ_HZ=160, SAMPLE_RATE_HZ=16, so ticks come every 10 cycles. BRAM is modelled as `mem[a] = a[7:0]` with latency 1.
- Reset, no requests -> `sample_tick` pulses every 10 cycles; `audio_sample_out` = 0x80; `busy` = `done` = 0.
- start base=0x0010 len=3 loop=0 -> outputs 0x10, 0x11, 0x12 on successive ticks. `done` accompanies 0x12. Next tick gives 0x80 and `busy` = 0.
- start base=0x0020 len=2 loop=1, run 5 ticks -> 0x20, 0x21, 0x20, 0x21, 0x20; no `done`. `stop` -> next tick 0x80, no `done`.
- start base=0xFFFE len=4 -> `bram_addr` goes 0xFFFE, 0xFFFF, 0x0000, 0x0001; outputs 0xFE, 0xFF, 0x00, 0x01.
- start coincident with tick, then start+stop together, then start with len=0 -> first tick emits 0x80 and the clip begins on the following tick; start+stop causes IDLE; len=0 request causes no `busy`.
- RESET_N asserted mid-clip -> all outputs at reset values in the same cycle. After release, the divider restarts from 0 and the first `sample_tick` comes 11 cycles later.
